// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and helpers shared by the alu_seq block.
// Optional feature macro: ALU_SEQ_DIV_EN (makes DIVU a legal, iterative opcode).
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_DIVU = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MULT = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU);
`else
        return op == OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: WIDTH-step shift-add signed multiplier and (with ALU_SEQ_DIV_EN) restoring
// unsigned divider. res_lo/res_hi show the result as it will stand after the current step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             last,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        // b's top bit weighs -2^(WIDTH-1), so its partial product is subtracted instead of added.
        acc_nxt = last ? (acc - addend) : (acc + addend);
    end

    // NOTE: datapath registers are fully reloaded at every launch, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier <= b;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             div_mode;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // With dvsr == 0 every trial fits, giving an all-ones quotient and remainder == a.
    always_comb begin
        trial   = {rem, quo[WIDTH-1]};
        diff    = trial - {1'b0, dvsr};
        fits    = trial >= {1'b0, dvsr};
        rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem      <= '0;
            quo      <= a;
            dvsr     <= b;
            div_mode <= is_div;
        end else if (step) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

    assign res_lo = div_mode ? quo_nxt : acc_nxt[WIDTH-1:0];
    assign res_hi = div_mode ? rem_nxt : acc_nxt[2*WIDTH-1:WIDTH];
`else
    assign res_lo = acc_nxt[WIDTH-1:0];
    assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with start/done handshake and registered results.
// Optional feature macro: ALU_SEQ_DIV_EN (iterative unsigned divide; otherwise DIVU is illegal).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             ovfl,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             launch;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic             iter_ovfl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] sc_r;
    logic             sc_ovfl;
    logic             sc_illegal;

    assign busy   = (state == ST_MULT) || (state == ST_DIV);
    assign done   = (state == ST_DONE);
    assign launch = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign load   = launch && is_iter(op);
    assign last   = (cnt == CNT_LAST);

    always_comb begin
        sum        = a + b;
        dif        = a - b;
        sc_r       = '0;
        sc_ovfl    = 1'b0;
        sc_illegal = 1'b0;
        case (op)
            OP_AND:  sc_r = a & b;
            OP_OR:   sc_r = a | b;
            OP_NOR:  sc_r = ~(a | b);
            OP_ADD: begin
                sc_r    = sum;
                sc_ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Adding -b: overflow when a and -b agree in sign and the result does not.
                sc_r    = dif;
                sc_ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_r = {{(WIDTH-1){1'b0}}, a < b};
            default: sc_illegal = 1'b1;
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .load   (load),
        .step   (busy),
        .last   (last),
`ifdef ALU_SEQ_DIV_EN
        .is_div (op == OP_DIVU),
`endif
        .a      (a),
        .b      (b),
        .res_lo (iter_lo),
        .res_hi (iter_hi)
    );

`ifdef ALU_SEQ_DIV_EN
    logic div0;
    assign iter_ovfl = (state == ST_DIV) ? div0 : (iter_hi != {WIDTH{iter_lo[WIDTH-1]}});
`else
    assign iter_ovfl = (iter_hi != {WIDTH{iter_lo[WIDTH-1]}});
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            r       <= '0;
            r_hi    <= '0;
            zero    <= 1'b0;
            ovfl    <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div0    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (!launch) begin
                        state <= ST_IDLE;
                    end else if (is_iter(op)) begin
                        cnt <= '0;
`ifdef ALU_SEQ_DIV_EN
                        state <= (op == OP_MUL) ? ST_MULT : ST_DIV;
                        div0  <= (b == '0);
`else
                        state <= ST_MULT;
`endif
                    end else begin
                        state   <= ST_DONE;
                        r       <= sc_r;
                        r_hi    <= '0;
                        zero    <= (sc_r == '0);
                        ovfl    <= sc_ovfl;
                        illegal <= sc_illegal;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_MULT, ST_DIV: begin
`else
                ST_MULT: begin
`endif
                    if (last) begin
                        state   <= ST_DONE;
                        cnt     <= '0;
                        r       <= iter_lo;
                        r_hi    <= iter_hi;
                        zero    <= (iter_lo == '0);
                        ovfl    <= iter_ovfl;
                        illegal <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
